sp_unit: RTL and testbench
==========================

SP_UNIT -- requirements
Module: sp_unit

Interface
REQ-001 Parameter WIDTH, default 32: stack pointer width in bits.
REQ-002 Parameter STEP, default 4: bytes per stack slot; SHALL be a power of two.
REQ-003 Parameter TOP, default 32'h0000_1000: empty-stack pointer value and reset value of sp.
REQ-004 Parameter BOTTOM, default 32'h0000_0800: full-stack pointer value; TOP > BOTTOM and (TOP-BOTTOM) SHALL be a multiple of STEP.
REQ-005 Derived DEPTH = (TOP-BOTTOM)/STEP; CW = clog2(DEPTH+1).
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  operation enable; when low no op is accepted and sp/count/ack hold (ack drops to 0).
REQ-009 push  input  1  pre-decrement sp by STEP.
REQ-010 pop  input  1  post-increment sp by STEP.
REQ-011 load  input  1  write load_val into sp.
REQ-012 load_val  input  WIDTH  absolute value for load.
REQ-013 adj  input  1  add sign-extended adj_off to sp (addi sp form).
REQ-014 adj_off  input  12  signed byte offset for adj.
REQ-015 clr_err  input  1  synchronous clear of sticky error flags; not gated by en.
REQ-016 sp  output  WIDTH  registered stack pointer; addresses current top element.
REQ-017 wr_addr  output  WIDTH  combinational sp-STEP (slot a push writes).
REQ-018 count  output  CW  occupied slots, (TOP-sp)/STEP, combinational from sp.
REQ-019 full / empty  output  1 each  sp==BOTTOM / sp==TOP.
REQ-020 ack  output  1  registered; high one cycle after any accepted operation.
REQ-021 ovf / unf / rng_err  output  1 each  sticky overflow, underflow, range-error flags.

Function
REQ-022 Op priority per cycle when en=1: load > adj > push/pop; lower-priority requests that cycle are ignored and set no flags.
REQ-023 push alone, not full: sp <= sp-STEP next edge.
REQ-024 pop alone, not empty: sp <= sp+STEP next edge.
REQ-025 push and pop same cycle: sp unchanged, accepted (ack=1) even when full or empty; no flags.
REQ-026 push alone while full: rejected, sp holds, ovf<=1, ack=0.
REQ-027 pop alone while empty: rejected, sp holds, unf<=1, ack=0.
REQ-028 Candidate value v for load (load_val) or adj (sp + sext(adj_off), modulo 2^WIDTH) is valid iff BOTTOM <= v <= TOP and v[log2(STEP)-1:0] == TOP[log2(STEP)-1:0].
REQ-029 Valid v: sp <= v, ack=1; invalid v: sp holds, rng_err<=1, ack=0.
REQ-030 adj with adj_off=0 is accepted, sp unchanged, ack=1.
REQ-031 Sticky flags set on the edge after the offending cycle and hold until clr_err or reset.
REQ-032 clr_err coincident with a new error: set wins (flag remains 1).
REQ-033 count/full/empty/wr_addr SHALL follow sp combinationally with zero cycle latency; count never exceeds DEPTH.
REQ-034 No op requested with en=1: sp holds, ack=0.

Reset
REQ-035 rstn low asynchronously forces sp=TOP, ack=0, ovf=0, unf=0, rng_err=0; hence count=0, empty=1, full=0, wr_addr=TOP-STEP.
REQ-036 Reset asserted mid-operation discards the pending op; first op is accepted on the first rising edge after rstn deasserts.

Verification
REQ-037 Reset, then 3 pushes (defaults) -> sp=0xFF4, count=3, ack high each following cycle; 3 pops -> sp=0x1000, empty=1.
REQ-038 Push 512 times -> sp=0x800, full=1, count=512; 513th push -> sp stays 0x800, ovf=1, ack=0; clr_err -> ovf=0.
REQ-039 From empty, pop -> unf=1, sp=0x1000; push+pop together while full and while empty -> sp unchanged, ack=1, no flags.
REQ-040 load 0xC00 -> sp=0xC00, count=256; load 0xC02 (misaligned) and load 0x1004 (above TOP) -> sp stays 0xC00, rng_err=1.
REQ-041 sp=0x1000, adj adj_off=-16 -> sp=0xFF0; adj +32 -> rejected, rng_err=1; load+push same cycle -> only load applied.
REQ-042 en=0 with push held -> sp unchanged, ack=0; assert rstn low mid-sequence -> sp=0x1000 immediately, flags 0.

Source files
------------

// File: rtl/sp_unit.sv
// Hardware stack-pointer unit: push/pop/load/adjust with bounds checking and sticky error flags.
// Derived views of sp (count, full, empty, wr_addr) are combinational; sp, ack and flags are registered.
module sp_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STEP   = 4,
  parameter logic [WIDTH-1:0] TOP    = WIDTH'(32'h0000_1000),
  parameter logic [WIDTH-1:0] BOTTOM = WIDTH'(32'h0000_0800),
  localparam int unsigned DEPTH = int'((TOP - BOTTOM) / WIDTH'(STEP)),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             adj,
  input  logic [11:0]      adj_off,
  input  logic             clr_err,
  output logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] wr_addr,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             ack,
  output logic             ovf,
  output logic             unf,
  output logic             rng_err
);

  localparam int unsigned      SHW        = $clog2(STEP);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  logic [WIDTH-1:0] sp_nxt;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] adj_sext;
  logic [WIDTH-1:0] occ_bytes;
  logic             cand_ok;
  logic             ack_nxt;
  logic             ovf_set;
  logic             unf_set;
  logic             rng_set;

  // Derived views follow sp with no latency
  assign occ_bytes = TOP - sp;
  assign count     = CW'(occ_bytes >> SHW);
  assign full      = (sp == BOTTOM);
  assign empty     = (sp == TOP);
  assign wr_addr   = sp - STEP_W;

  assign adj_sext = {{(WIDTH-12){adj_off[11]}}, adj_off};
  assign cand     = load ? load_val : (sp + adj_sext);
  assign cand_ok  = (cand >= BOTTOM) && (cand <= TOP) &&
                    ((cand & ALIGN_MASK) == (TOP & ALIGN_MASK));

  // Operation select: load > adj > push/pop
  always_comb begin
    sp_nxt  = sp;
    ack_nxt = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    rng_set = 1'b0;
    if (en) begin
      if (load || adj) begin
        if (cand_ok) begin
          sp_nxt  = cand;
          ack_nxt = 1'b1;
        end else begin
          rng_set = 1'b1;
        end
      end else if (push && pop) begin
        ack_nxt = 1'b1;
      end else if (push) begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          sp_nxt  = sp - STEP_W;
          ack_nxt = 1'b1;
        end
      end else if (pop) begin
        if (empty) begin
          unf_set = 1'b1;
        end else begin
          sp_nxt  = sp + STEP_W;
          ack_nxt = 1'b1;
        end
      end
    end
  end

  // A new error outranks a coincident clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sp      <= TOP;
      ack     <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      rng_err <= 1'b0;
    end else begin
      sp      <= sp_nxt;
      ack     <= ack_nxt;
      ovf     <= ovf_set | (ovf     & ~clr_err);
      unf     <= unf_set | (unf     & ~clr_err);
      rng_err <= rng_set | (rng_err & ~clr_err);
    end
  end

endmodule

// File: tb/tb_sp_unit.sv
// Directed testbench for sp_unit with default parameters (TOP=0x1000, BOTTOM=0x800, STEP=4).
module tb_sp_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        push;
  logic        pop;
  logic        load;
  logic [31:0] load_val;
  logic        adj;
  logic [11:0] adj_off;
  logic        clr_err;
  logic [31:0] sp;
  logic [31:0] wr_addr;
  logic [9:0]  count;
  logic        full;
  logic        empty;
  logic        ack;
  logic        ovf;
  logic        unf;
  logic        rng_err;

  int errors = 0;
  int checks = 0;

  sp_unit dut (
    .clk(clk), .rstn(rstn), .en(en), .push(push), .pop(pop),
    .load(load), .load_val(load_val), .adj(adj), .adj_off(adj_off),
    .clr_err(clr_err), .sp(sp), .wr_addr(wr_addr), .count(count),
    .full(full), .empty(empty), .ack(ack), .ovf(ovf), .unf(unf),
    .rng_err(rng_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    push = 1'b0; pop = 1'b0; load = 1'b0; adj = 1'b0; clr_err = 1'b0;
    load_val = '0; adj_off = '0;
  endtask

  // Apply one cycle of stimulus, then sample just after the edge
  task automatic op(input logic p_push, input logic p_pop, input logic p_load,
                    input logic [31:0] p_lv, input logic p_adj, input logic [11:0] p_off,
                    input logic p_clr);
    push = p_push; pop = p_pop; load = p_load; load_val = p_lv;
    adj = p_adj; adj_off = p_off; clr_err = p_clr;
    @(posedge clk); #1;
    clear_in();
  endtask

  initial begin
    rstn = 1'b0; en = 1'b1;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sp", sp, 32'h1000);
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_wr_addr", wr_addr, 32'hFFC);
    check("rst_ack", 32'(ack), 0);
    check("rst_flags", {29'd0, ovf, unf, rng_err}, 0);
    rstn = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      op(1, 0, 0, 0, 0, 0, 0);
      check("push_ack", 32'(ack), 1);
      check("push_sp", sp, 32'h1000 - 32'(4 * i));
    end
    check("push3_count", 32'(count), 3);
    check("push3_wr_addr", wr_addr, 32'hFF0);
    for (int i = 1; i <= 3; i++) begin
      op(0, 1, 0, 0, 0, 0, 0);
      check("pop_ack", 32'(ack), 1);
    end
    check("pop3_sp", sp, 32'h1000);
    check("pop3_empty", 32'(empty), 1);

    op(0, 1, 0, 0, 0, 0, 0);
    check("unf_set", 32'(unf), 1);
    check("unf_ack", 32'(ack), 0);
    check("unf_sp", sp, 32'h1000);
    op(0, 0, 0, 0, 0, 0, 1);
    check("unf_clr", 32'(unf), 0);
    op(1, 1, 0, 0, 0, 0, 0);
    check("pp_empty_sp", sp, 32'h1000);
    check("pp_empty_ack", 32'(ack), 1);
    check("pp_empty_flags", {29'd0, ovf, unf, rng_err}, 0);

    for (int i = 0; i < 512; i++) op(1, 0, 0, 0, 0, 0, 0);
    check("fill_sp", sp, 32'h800);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 512);
    op(1, 0, 0, 0, 0, 0, 0);
    check("ovf_sp", sp, 32'h800);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_ack", 32'(ack), 0);
    op(1, 1, 0, 0, 0, 0, 0);
    check("pp_full_sp", sp, 32'h800);
    check("pp_full_ack", 32'(ack), 1);
    check("ovf_sticky", 32'(ovf), 1);
    op(0, 0, 0, 0, 0, 0, 1);
    check("ovf_clr", 32'(ovf), 0);
    op(1, 0, 0, 0, 0, 0, 1);
    check("ovf_set_wins", 32'(ovf), 1);
    op(0, 0, 0, 0, 0, 0, 1);
    check("ovf_clr2", 32'(ovf), 0);

    op(0, 0, 1, 32'hC00, 0, 0, 0);
    check("load_sp", sp, 32'hC00);
    check("load_count", 32'(count), 256);
    check("load_ack", 32'(ack), 1);
    op(0, 0, 1, 32'hC02, 0, 0, 0);
    check("mis_sp", sp, 32'hC00);
    check("mis_rng", 32'(rng_err), 1);
    check("mis_ack", 32'(ack), 0);
    op(0, 0, 0, 0, 0, 0, 1);
    check("rng_clr", 32'(rng_err), 0);
    op(0, 0, 1, 32'h1004, 0, 0, 0);
    check("above_sp", sp, 32'hC00);
    check("above_rng", 32'(rng_err), 1);
    op(0, 0, 0, 0, 0, 0, 1);

    op(0, 0, 1, 32'h1000, 0, 0, 0);
    op(0, 0, 0, 0, 1, 12'hFF0, 0);
    check("adj_neg_sp", sp, 32'hFF0);
    check("adj_neg_ack", 32'(ack), 1);
    op(0, 0, 0, 0, 1, 12'd32, 0);
    check("adj_pos_sp", sp, 32'hFF0);
    check("adj_pos_rng", 32'(rng_err), 1);
    op(0, 0, 0, 0, 0, 0, 1);
    op(0, 0, 0, 0, 1, 12'd0, 0);
    check("adj0_sp", sp, 32'hFF0);
    check("adj0_ack", 32'(ack), 1);
    op(0, 1, 0, 0, 1, 12'd32, 0);
    check("adj_pop_unf", 32'(unf), 0);
    check("adj_pop_sp", sp, 32'hFF0);
    op(0, 0, 0, 0, 0, 0, 1);
    op(1, 0, 1, 32'hC00, 0, 0, 0);
    check("load_push_sp", sp, 32'hC00);

    en = 1'b0;
    op(1, 0, 0, 0, 0, 0, 0);
    check("en0_sp", sp, 32'hC00);
    check("en0_ack", 32'(ack), 0);
    op(0, 0, 0, 0, 0, 0, 0);
    check("idle_ack", 32'(ack), 0);
    en = 1'b1;
    op(0, 0, 0, 0, 0, 0, 0);
    check("noop_ack", 32'(ack), 0);
    check("noop_sp", sp, 32'hC00);

    op(0, 0, 1, 32'h0, 0, 0, 0);
    check("low_rng", 32'(rng_err), 1);
    push = 1'b1;
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst_sp", sp, 32'h1000);
    check("async_rst_flags", {29'd0, ovf, unf, rng_err}, 0);
    clear_in();
    @(posedge clk); #1;
    rstn = 1'b1;
    op(1, 0, 0, 0, 0, 0, 0);
    check("post_rst_sp", sp, 32'hFFC);
    check("post_rst_ack", 32'(ack), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
